sonar_sweep_ctrl: RTL and testbench
===================================

SONAR_SWEEP_CTRL -- requirements
Module: sonar_sweep_ctrl

Interface
REQ-001 Parameter N_POS, default 8, number of servo positions per sweep (1..64).
REQ-002 Parameter N_TX, default 8, bytes transmitted per measurement (1..16).
REQ-003 Parameter SETTLE_CYCLES, default 4, servo settle wait after each position change (>=1).
REQ-004 Parameter TIMEOUT_CYCLES, default 1000, sensor wait limit (>=2).
REQ-005 clock  input  1  system clock, rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 ligar  input  1  run enable; low forces IDLE.
REQ-008 modo  input  1  0 = ping-pong sweep, 1 = wrap sweep.
REQ-009 sensor_pronto  input  1  measurement complete, single-cycle pulse or level.
REQ-010 serial_pronto  input  1  UART byte accepted/done.
REQ-011 medir  output  1  one-cycle measurement start pulse.
REQ-012 transmissao  output  1  byte transmit request, high throughout TX.
REQ-013 sel_posicao  output  $clog2(N_POS) (min 1)  current servo position index.
REQ-014 sel_transmissao  output  $clog2(N_TX) (min 1)  byte index being sent.
REQ-015 fim_posicao  output  1  one-cycle pulse when a position completes.
REQ-016 timeout  output  1  one-cycle pulse on sensor timeout.
REQ-017 db_estado  output  4  registered copy of state code, one cycle late.

Function
REQ-018 States SHALL be IDLE, PREP, SETTLE, MEDIR, WAIT, TX, NEXT; outputs decoded from state plus registered counters only (Moore).
REQ-019 IDLE -> PREP when ligar=1; PREP -> SETTLE with sel_posicao=0, direction=up, settle counter cleared.
REQ-020 SETTLE lasts exactly SETTLE_CYCLES cycles, then MEDIR.
REQ-021 MEDIR lasts one cycle asserting medir=1, then WAIT.
REQ-022 WAIT -> TX on sensor_pronto=1, sel_transmissao cleared to 0.
REQ-023 TX: transmissao=1; on serial_pronto=1 increment sel_transmissao; on serial_pronto with sel_transmissao=N_TX-1 go to NEXT.
REQ-024 NEXT lasts one cycle, fim_posicao=1, updates sel_posicao, then SETTLE.
REQ-025 Ping-pong: up increments; at N_POS-1 direction flips and index goes to N_POS-2; down at 0 flips and goes to 1.
REQ-026 Wrap: index N_POS-1 -> 0; direction fixed up.
REQ-027 modo sampled only in NEXT; switching to wrap while moving down continues from current index upward.
REQ-028 N_POS=1: sel_posicao stays 0 in both modes; sweep repeats measure/transmit.
REQ-029 ligar=0 in any state: next cycle IDLE, all counters cleared, no further medir/transmissao; resume restarts at PREP, position 0.
REQ-030 sensor_pronto outside WAIT and serial_pronto outside TX SHALL be ignored.
REQ-031 Unused state encodings SHALL return to IDLE next cycle.

Reset
REQ-032 Reset SHALL force IDLE, sel_posicao=0, sel_transmissao=0, direction=up, all counters 0, db_estado=0.
REQ-033 All outputs 0 during and after reset until the FSM leaves IDLE.

Configuration
REQ-034 With SONAR_TIMEOUT_EN defined: WAIT counts cycles; after TIMEOUT_CYCLES without sensor_pronto, go to NEXT, pulse timeout=1 in that NEXT cycle, skip TX.
REQ-035 Without SONAR_TIMEOUT_EN: WAIT waits indefinitely, timeout tied 0, no timeout counter synthesised.

Structure
REQ-036 Package sonar_pkg SHALL hold the state typedef/encodings and mode constants MODO_PINGPONG=0, MODO_WRAP=1.
REQ-037 One sub-module, sonar_pos_seq, SHALL hold position index and direction logic (inputs: advance, clear, modo).

Verification
REQ-038 N_POS=4, modo=0, immediate sensor_pronto/serial_pronto -> sel_posicao sequence 0,1,2,3,2,1,0,1.
REQ-039 N_POS=4, modo=1 -> sequence 0,1,2,3,0,1; fim_posicao one pulse per position.
REQ-040 N_TX=8, serial_pronto every 5th cycle -> sel_transmissao 0..7, exactly 8 accepted bytes, then NEXT; SETTLE measured as 4 cycles before medir.
REQ-041 SONAR_TIMEOUT_EN, TIMEOUT_CYCLES=20, sensor_pronto never asserted -> timeout pulse 20 cycles after entering WAIT, no transmissao, position advances.
REQ-042 ligar dropped mid-TX at byte 3 -> IDLE next cycle; ligar re-raised -> PREP, sel_posicao=0, sel_transmissao=0.
REQ-043 Reset asserted asynchronously mid-WAIT -> outputs 0 immediately, db_estado=0 after the next clock edge.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared types for the sonar sweep controller: FSM state encodings,
// sweep-mode constants and the index-width helper.
package sonar_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        PREP   = 4'd1,
        SETTLE = 4'd2,
        MEDIR  = 4'd3,
        WAIT   = 4'd4,
        TX     = 4'd5,
        NEXT   = 4'd6
    } state_t;

    localparam logic MODO_PINGPONG = 1'b0;
    localparam logic MODO_WRAP     = 1'b1;

    // Index width for a counter over n values, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sonar_sweep_ctrl_if.sv
// Control/status bundle between the sweep controller and the servo, sensor
// and UART side. The master drives the run controls and done strobes.
interface sonar_sweep_ctrl_if #(
    parameter int POS_W = 3,
    parameter int TX_W  = 3
);
    // sensor_pronto / serial_pronto are done-strobes: the controller only acts
    // on sensor_pronto while waiting for a measurement and on serial_pronto
    // while transmitting; a level held high counts once per clock in that state.
    logic             ligar;
    logic             modo;
    logic             sensor_pronto;
    logic             serial_pronto;
    logic             medir;
    logic             transmissao;
    logic [POS_W-1:0] sel_posicao;
    logic [TX_W-1:0]  sel_transmissao;
    logic             fim_posicao;
    logic             timeout;
    logic [3:0]       db_estado;

    modport master (
        output ligar, modo, sensor_pronto, serial_pronto,
        input  medir, transmissao, sel_posicao, sel_transmissao,
               fim_posicao, timeout, db_estado
    );

    modport slave (
        input  ligar, modo, sensor_pronto, serial_pronto,
        output medir, transmissao, sel_posicao, sel_transmissao,
               fim_posicao, timeout, db_estado
    );

endinterface

// File: rtl/sonar_pos_seq.sv
// Servo position sequencer: holds the position index and sweep direction,
// stepping once per advance in ping-pong or wrap order.
module sonar_pos_seq
    import sonar_pkg::*;
#(
    parameter int N_POS = 8,
    parameter int POS_W = idx_width(N_POS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic             modo,
    output logic [POS_W-1:0] pos
);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_POS - 1);

    logic [POS_W-1:0] pos_q;
    logic             dir_up_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos_q    <= '0;
            dir_up_q <= 1'b1;
        end else if (clear) begin
            pos_q    <= '0;
            dir_up_q <= 1'b1;
        end else if (advance) begin
            if (N_POS == 1) begin
                pos_q    <= '0;
                dir_up_q <= 1'b1;
            end else if (modo == MODO_WRAP) begin
                // Wrap always climbs, even if ping-pong had been heading down.
                dir_up_q <= 1'b1;
                pos_q    <= (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
            end else if (dir_up_q) begin
                if (pos_q == POS_LAST) begin
                    dir_up_q <= 1'b0;
                    pos_q    <= pos_q - 1'b1;
                end else begin
                    pos_q <= pos_q + 1'b1;
                end
            end else begin
                if (pos_q == '0) begin
                    dir_up_q <= 1'b1;
                    pos_q    <= pos_q + 1'b1;
                end else begin
                    pos_q <= pos_q - 1'b1;
                end
            end
        end
    end

    assign pos = pos_q;

endmodule

// File: rtl/sonar_sweep_ctrl.sv
// Sonar sweep controller: steps a servo, settles, triggers a measurement and
// streams N_TX bytes per position. Define SONAR_TIMEOUT_EN for a sensor timeout.
module sonar_sweep_ctrl
    import sonar_pkg::*;
#(
    parameter int N_POS          = 8,
    parameter int N_TX           = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clock,
    input  logic              reset,
    sonar_sweep_ctrl_if.slave bus
);

    localparam int POS_W = idx_width(N_POS);
    localparam int TX_W  = idx_width(N_TX);
    localparam int SET_W = idx_width(SETTLE_CYCLES);

    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TX_W-1:0]  TX_LAST     = TX_W'(N_TX - 1);

    state_t           state_q, state_d;
    logic [SET_W-1:0] settle_q;
    logic [TX_W-1:0]  tx_q;
    logic [3:0]       db_q;
    logic [POS_W-1:0] pos;
    logic             pos_clear;
    logic             wait_expired;
    logic             timeout_out;

`ifdef SONAR_TIMEOUT_EN
    localparam int WAIT_W = idx_width(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_q;
    logic              timed_out_q;

    assign wait_expired = (wait_q == WAIT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_q      <= '0;
            timed_out_q <= 1'b0;
        end else begin
            wait_q      <= (!bus.ligar || state_q != WAIT) ? '0 : wait_q + 1'b1;
            // Remembers that the coming NEXT was reached by giving up on the sensor.
            timed_out_q <= bus.ligar && (state_q == WAIT) && !bus.sensor_pronto && wait_expired;
        end
    end

    assign timeout_out = (state_q == NEXT) && timed_out_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign wait_expired = 1'b0;
    assign timeout_out  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.ligar) state_d = PREP;
            PREP:    state_d = SETTLE;
            SETTLE:  if (settle_q == SETTLE_LAST) state_d = MEDIR;
            MEDIR:   state_d = WAIT;
            WAIT: begin
                if (bus.sensor_pronto)  state_d = TX;
                else if (wait_expired)  state_d = NEXT;
            end
            TX:      if (bus.serial_pronto && tx_q == TX_LAST) state_d = NEXT;
            NEXT:    state_d = SETTLE;
            default: state_d = IDLE;
        endcase
        if (!bus.ligar) state_d = IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            settle_q <= '0;
            tx_q     <= '0;
            db_q     <= 4'd0;
        end else begin
            settle_q <= (!bus.ligar || state_q != SETTLE) ? '0 : settle_q + 1'b1;
            if (!bus.ligar || state_q == WAIT)
                tx_q <= '0;
            else if (state_q == TX && bus.serial_pronto)
                tx_q <= (tx_q == TX_LAST) ? '0 : tx_q + 1'b1;
            db_q <= state_q;
        end
    end

    assign pos_clear = !bus.ligar || (state_q == IDLE) || (state_q == PREP);

    sonar_pos_seq #(
        .N_POS (N_POS),
        .POS_W (POS_W)
    ) u_pos_seq (
        .clock   (clock),
        .reset   (reset),
        .clear   (pos_clear),
        .advance (state_q == NEXT),
        .modo    (bus.modo),
        .pos     (pos)
    );

    assign bus.medir           = (state_q == MEDIR);
    assign bus.transmissao     = (state_q == TX);
    assign bus.fim_posicao     = (state_q == NEXT);
    assign bus.timeout         = timeout_out;
    assign bus.sel_posicao     = pos;
    assign bus.sel_transmissao = tx_q;
    assign bus.db_estado       = db_q;

endmodule

// File: tb/tb_sonar_sweep_ctrl.sv
// Bench for sonar_sweep_ctrl: table-driven sweep orders checked through a
// position scoreboard, plus hand sequences for TX pacing, ligar drop, timeout and reset.
module tb_sonar_sweep_ctrl;
    import sonar_pkg::*;

    localparam int N_POS          = 4;
    localparam int N_TX           = 8;
    localparam int SETTLE_CYCLES  = 4;
    localparam int TIMEOUT_CYCLES = 20;
    localparam int POS_W          = idx_width(N_POS);
    localparam int TX_W           = idx_width(N_TX);

    localparam int SIG_MEDIR = 0;
    localparam int SIG_TX    = 1;
    localparam int SIG_FIM   = 2;

`ifdef SONAR_TIMEOUT_EN
    localparam int POS_BEFORE_RESET = 2;
`else
    localparam int POS_BEFORE_RESET = 1;
`endif

    // clock / reset
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sonar_sweep_ctrl_if #(.POS_W(POS_W), .TX_W(TX_W)) bus ();

    sonar_sweep_ctrl #(
        .N_POS          (N_POS),
        .N_TX           (N_TX),
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic                  modo;
        int                    count;
        int                    switch_after;
        logic [0:7][POS_W-1:0] seq;
    } vec_t;

    vec_t             vecs[3];
    logic [POS_W-1:0] exp_q[$];
    logic             sb_en = 1'b0;
    int               fim_cnt = 0;
    int               n_cmp = 0;
    int               n_fail = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock, then sample away from the edge; scoreboard pops on each medir.
    task automatic step();
        logic [POS_W-1:0] e;
        @(posedge clock);
        #1;
        if (sb_en) begin
            if (bus.fim_posicao) fim_cnt++;
            if (bus.medir) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_medir", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_sel_posicao", int'(bus.sel_posicao), int'(e));
                end
            end
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            SIG_MEDIR: return bus.medir;
            SIG_TX:    return bus.transmissao;
            default:   return bus.fim_posicao;
        endcase
    endfunction

    task automatic wait_sig(input int which, input string nm, input int budget);
        int k;
        k = 0;
        while (!sig(which) && k < budget) begin
            step();
            k++;
        end
        check(nm, int'(sig(which)), 1);
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_medir"},  int'(bus.medir), 0);
        check({nm, "_tx"},     int'(bus.transmissao), 0);
        check({nm, "_pos"},    int'(bus.sel_posicao), 0);
        check({nm, "_sel_tx"}, int'(bus.sel_transmissao), 0);
        check({nm, "_fim"},    int'(bus.fim_posicao), 0);
        check({nm, "_tmo"},    int'(bus.timeout), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int cyc;
        int g;
        int t;
        logic tx_seen;
        logic fim_seen;

        vecs[0].modo = MODO_PINGPONG; vecs[0].count = 8; vecs[0].switch_after = 0;
        vecs[0].seq  = {2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
        vecs[1].modo = MODO_WRAP;     vecs[1].count = 6; vecs[1].switch_after = 0;
        vecs[1].seq  = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0};
        vecs[2].modo = MODO_PINGPONG; vecs[2].count = 8; vecs[2].switch_after = 5;
        vecs[2].seq  = {2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0, 2'd1};

        // Reset held with ligar high: the FSM must stay quiet.
        reset = 1'b1;
        bus.ligar = 1'b1;
        bus.modo = MODO_PINGPONG;
        bus.sensor_pronto = 1'b0;
        bus.serial_pronto = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        check("reset_db", int'(bus.db_estado), 0);
        bus.ligar = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        step();
        step();
        check_idle_outputs("post_reset");
        check("post_reset_db", int'(bus.db_estado), int'(IDLE));

        // Table: sweep order per mode, scoreboard checks sel_posicao at each medir.
        for (int v = 0; v < 3; v++) begin
            bus.ligar = 1'b0;
            step();
            step();
            bus.modo = vecs[v].modo;
            bus.sensor_pronto = 1'b1;
            bus.serial_pronto = 1'b1;
            for (int i = 0; i < vecs[v].count; i++) exp_q.push_back(vecs[v].seq[i]);
            fim_cnt = 0;
            sb_en = 1'b1;
            bus.ligar = 1'b1;
            for (int k = 0; k < 600 && exp_q.size() != 0; k++) begin
                step();
                if (vecs[v].switch_after > 0 &&
                    vecs[v].count - exp_q.size() == vecs[v].switch_after)
                    bus.modo = MODO_WRAP;
            end
            sb_en = 1'b0;
            check("sweep_drained", exp_q.size(), 0);
            check("fim_pulses", fim_cnt, vecs[v].count - 1);
            exp_q.delete();
        end

        // Paced UART: serial_pronto every 5th cycle, 8 bytes, then NEXT and settle.
        bus.ligar = 1'b0;
        step();
        step();
        bus.modo = MODO_PINGPONG;
        bus.sensor_pronto = 1'b1;
        bus.serial_pronto = 1'b0;
        bus.ligar = 1'b1;
        wait_sig(SIG_TX, "paced_tx_start", 100);
        accepted = 0;
        cyc = 0;
        for (int k = 0; k < 200 && accepted < N_TX; k++) begin
            if (cyc % 5 == 4) begin
                check("paced_tx_held", int'(bus.transmissao), 1);
                check("paced_byte_index", int'(bus.sel_transmissao), accepted);
                bus.serial_pronto = 1'b1;
                accepted++;
            end else begin
                bus.serial_pronto = 1'b0;
            end
            cyc++;
            step();
        end
        bus.serial_pronto = 1'b0;
        check("paced_next_fim", int'(bus.fim_posicao), 1);
        check("paced_next_tx_low", int'(bus.transmissao), 0);
        g = 0;
        while (!bus.medir && g < 50) begin
            step();
            g++;
        end
        check("settle_gap", g, SETTLE_CYCLES + 1);
        check("paced_pos_advanced", int'(bus.sel_posicao), 1);

        // ligar dropped at byte 3, then resumed from position 0.
        bus.serial_pronto = 1'b1;
        wait_sig(SIG_TX, "drop_tx_start", 50);
        g = 0;
        while (bus.sel_transmissao != 3 && g < 20) begin
            step();
            g++;
        end
        check("drop_at_byte3", int'(bus.sel_transmissao), 3);
        check("drop_pos_before", int'(bus.sel_posicao), 1);
        bus.ligar = 1'b0;
        bus.serial_pronto = 1'b0;
        step();
        check_idle_outputs("drop");
        step();
        check("drop_db_idle", int'(bus.db_estado), int'(IDLE));
        bus.ligar = 1'b1;
        step();
        step();
        check("resume_db_prep", int'(bus.db_estado), int'(PREP));
        check("resume_pos", int'(bus.sel_posicao), 0);
        check("resume_sel_tx", int'(bus.sel_transmissao), 0);
        wait_sig(SIG_MEDIR, "resume_medir", 50);
        check("resume_medir_pos", int'(bus.sel_posicao), 0);

        // Sensor never answers.
        bus.sensor_pronto = 1'b0;
        t = 0;
        tx_seen = 1'b0;
        fim_seen = 1'b0;
        while (!bus.timeout && t < 60) begin
            step();
            t++;
            if (bus.transmissao) tx_seen = 1'b1;
            if (bus.fim_posicao) fim_seen = 1'b1;
        end
        check("silent_no_tx", int'(tx_seen), 0);
`ifdef SONAR_TIMEOUT_EN
        check("timeout_latency", t, TIMEOUT_CYCLES + 1);
        check("timeout_in_next", int'(bus.fim_posicao), 1);
        step();
        check("timeout_one_cycle", int'(bus.timeout), 0);
        wait_sig(SIG_MEDIR, "after_timeout_medir", 50);
        check("pos_after_timeout", int'(bus.sel_posicao), 1);
`else
        check("no_timeout", int'(bus.timeout), 0);
        check("wait_no_fim", int'(fim_seen), 0);
        check("wait_held_db", int'(bus.db_estado), int'(WAIT));
        bus.sensor_pronto = 1'b1;
        step();
        check("wait_release_tx", int'(bus.transmissao), 1);
`endif

        // Asynchronous reset in the middle of WAIT.
        bus.sensor_pronto = 1'b1;
        bus.serial_pronto = 1'b1;
        wait_sig(SIG_FIM, "pre_reset_fim", 100);
        bus.sensor_pronto = 1'b0;
        wait_sig(SIG_MEDIR, "pre_reset_medir", 50);
        step();
        check("pre_reset_db_medir", int'(bus.db_estado), int'(MEDIR));
        check("pre_reset_pos", int'(bus.sel_posicao), POS_BEFORE_RESET);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        @(posedge clock);
        #1;
        check("async_reset_db", int'(bus.db_estado), 0);
        bus.ligar = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        step();
        check_idle_outputs("final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
